// File: rtl/ps2_cmd_sched.sv
// PS/2 host-to-device command scheduler: inhibit, request-to-send, 11-bit frame,
// line-ACK check, then device response handling with bounded resend.
module ps2_cmd_sched #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 1000000,
    parameter int RESP_TIMEOUT   = 1000000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] rx_byte,
    input  logic       rx_strobe,
    output logic       rx_inhibit,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_WAIT_RESP,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [19:0] C_INH_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] C_START_TO = 20'(START_TIMEOUT);
    localparam logic [19:0] C_XFER_TO  = 20'(XFER_TIMEOUT);
    localparam logic [19:0] C_RESP_TO  = 20'(RESP_TIMEOUT);
    localparam logic [19:0] C_TMR_MAX  = 20'hFFFFF;
    localparam logic [3:0]  C_MAX_RTY  = 4'(MAX_RETRY);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_clk_meta, r_clk_s0, r_clk_s1;
    logic        r_dat_meta, r_dat_s0;
    logic [19:0] r_tmr;
    logic [3:0]  r_bitcnt, w_bitcnt_nxt;
    logic        r_dat_bit, w_dat_bit_nxt;
    logic [3:0]  r_retry, w_retry_nxt;
    logic [1:0]  r_err_code, w_err_code_nxt;
    logic [7:0]  r_byte;
    logic        r_parity;
    logic        w_load;
    logic        w_fall;
    logic [3:0]  w_n;
    logic        w_inh_last;

    // Synchronizers idle high so reset release never looks like a clock fall.
    assign w_fall     = r_clk_s1 & ~r_clk_s0;
    assign w_n        = r_bitcnt + 4'd1;
    assign w_inh_last = (r_tmr >= C_INH_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_bitcnt_nxt   = r_bitcnt;
        w_dat_bit_nxt  = r_dat_bit;
        w_retry_nxt    = r_retry;
        w_err_code_nxt = r_err_code;
        w_load         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_load      = 1'b1;
                    w_retry_nxt = 4'd0;
                    w_state_nxt = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (w_inh_last)
                    w_state_nxt = S_REQ;
            end
            S_REQ: begin
                // First device fall is fall 1: data bit 0 goes out now.
                if (w_fall) begin
                    w_bitcnt_nxt  = 4'd1;
                    w_dat_bit_nxt = ~r_byte[0];
                    w_state_nxt   = S_SEND;
                end else if (r_tmr >= C_START_TO) begin
                    w_err_code_nxt = 2'd0;
                    w_state_nxt    = S_ERR;
                end
            end
            S_SEND: begin
                if (w_fall) begin
                    w_bitcnt_nxt = w_n;
                    if (w_n <= 4'd8) begin
                        w_dat_bit_nxt = ~r_byte[r_bitcnt[2:0]];
                    end else if (w_n == 4'd9) begin
                        w_dat_bit_nxt = ~r_parity;
                    end else if (w_n == 4'd10) begin
                        w_dat_bit_nxt = 1'b0;
                    end else if (r_dat_s0) begin
                        w_err_code_nxt = 2'd1;
                        w_state_nxt    = S_ERR;
                    end else begin
                        w_state_nxt = S_WAIT_RESP;
                    end
                end else if (r_tmr >= C_XFER_TO) begin
                    w_err_code_nxt = 2'd1;
                    w_state_nxt    = S_ERR;
                end
            end
            S_WAIT_RESP: begin
                if (rx_strobe) begin
                    if (rx_byte == 8'hFA) begin
                        w_state_nxt = S_DONE;
                    end else if (rx_byte == 8'hFE) begin
                        if (r_retry < C_MAX_RTY) begin
                            w_retry_nxt = r_retry + 4'd1;
                            w_state_nxt = S_INHIBIT;
                        end else begin
                            w_err_code_nxt = 2'd2;
                            w_state_nxt    = S_ERR;
                        end
                    end else begin
                        w_err_code_nxt = 2'd3;
                        w_state_nxt    = S_ERR;
                    end
                end else if (r_tmr >= C_RESP_TO) begin
                    w_err_code_nxt = 2'd3;
                    w_state_nxt    = S_ERR;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_clk_meta <= 1'b1;
            r_clk_s0   <= 1'b1;
            r_clk_s1   <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_s0   <= 1'b1;
            r_tmr      <= '0;
            r_bitcnt   <= '0;
            r_dat_bit  <= 1'b0;
            r_retry    <= '0;
            r_err_code <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_meta <= ps2_clk_in;
            r_clk_s0   <= r_clk_meta;
            r_clk_s1   <= r_clk_s0;
            r_dat_meta <= ps2_dat_in;
            r_dat_s0   <= r_dat_meta;
            r_bitcnt   <= w_bitcnt_nxt;
            r_dat_bit  <= w_dat_bit_nxt;
            r_retry    <= w_retry_nxt;
            r_err_code <= w_err_code_nxt;
            // Timer restarts on every state change and sticks at full scale.
            if (w_state_nxt != r_state)
                r_tmr <= '0;
            else if (r_tmr != C_TMR_MAX)
                r_tmr <= r_tmr + 20'd1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_load) begin
            r_byte   <= cmd_data;
            r_parity <= ~^cmd_data;
        end
    end

    // Line drives decode straight from state so reset releases them at once.
    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign ps2_clk_oe = (r_state == S_INHIBIT);
    assign ps2_dat_oe = ((r_state == S_INHIBIT) && w_inh_last) ||
                        (r_state == S_REQ) ||
                        ((r_state == S_SEND) && r_dat_bit);
    assign rx_inhibit = (r_state == S_INHIBIT) || (r_state == S_REQ) ||
                        (r_state == S_SEND);
    assign done       = (r_state == S_DONE);
    assign err        = (r_state == S_ERR);
    assign err_code   = r_err_code;

endmodule

// File: tb/tb_ps2_cmd_sched.sv
// Bench for ps2_cmd_sched: a PS/2 device model clocks frames out of the host
// and answers with response bytes; outcomes come from a transaction-level model.
module tb_ps2_cmd_sched;

    localparam int INH    = 40;
    localparam int ST_TO  = 300;
    localparam int XF_TO  = 2000;
    localparam int RSP_TO = 400;
    localparam int MR     = 3;

    logic       CLOCK_50  = 1'b0;
    logic       reset_n   = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data  = 8'h00;
    logic [7:0] rx_byte   = 8'h00;
    logic       rx_strobe = 1'b0;
    logic       cmd_ready, ps2_clk_oe, ps2_dat_oe, rx_inhibit, busy, done, err;
    logic [1:0] err_code;
    logic       ps2_clk_in, ps2_dat_in;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;

    // Open-collector wiring: either side can pull a line low.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_cmd_sched #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (ST_TO),
        .XFER_TIMEOUT  (XF_TO),
        .RESP_TIMEOUT  (RSP_TO),
        .MAX_RETRY     (MR)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .rx_byte   (rx_byte),
        .rx_strobe (rx_strobe),
        .rx_inhibit(rx_inhibit),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int         n_cmp = 0;
    int         n_mis = 0;
    int         cyc = 0;
    int         n_done = 0;
    int         n_errp = 0;
    int         t_req = -1;
    int         t_wr = -1;
    int         t_err = -1;
    logic [1:0] last_code = 2'd0;
    logic       prev_clkoe = 1'b0;
    logic       prev_rxinh = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and log pulses and phase-entry times seen in that cycle.
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        cyc++;
        if (prev_clkoe && !ps2_clk_oe && busy) t_req = cyc;
        if (prev_rxinh && !rx_inhibit && busy) t_wr = cyc;
        if (err) begin
            n_errp++;
            last_code = err_code;
            t_err = cyc;
        end
        if (done) n_done++;
        prev_clkoe = ps2_clk_oe;
        prev_rxinh = rx_inhibit;
    endtask

    task automatic accept(input logic [7:0] b);
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_data  = b;
        tick();
        cmd_valid = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
    endtask

    // Called in the first INHIBIT cycle; returns in the first REQ cycle.
    task automatic inhibit_phase();
        int hi = 0;
        int dat_at = -1;
        bit rx_ok = 1'b1;
        while (ps2_clk_oe && hi < INH + 20) begin
            if (ps2_dat_oe && dat_at < 0) dat_at = hi;
            if (!rx_inhibit || cmd_ready || !busy) rx_ok = 1'b0;
            hi++;
            tick();
        end
        chk("inhibit_len", hi, INH);
        chk("inhibit_dat_rise", dat_at, INH - 1);
        chk("inhibit_rx_off", rx_ok, 1'b1);
        chk("req_lines", {ps2_clk_oe, ps2_dat_oe, rx_inhibit}, 3'b011);
    endtask

    // Device side: clocks 11 bits, samples each on the rising edge, optionally
    // pulls DAT low before fall 11 as the line-ACK.
    task automatic device_xfer(input logic [7:0] b, input bit ack_ok,
                               input int abort_fall, input bit poke);
        int hp = $urandom_range(8, 14);
        logic [9:0] cap = '0;
        logic [9:0] expf;
        chk("start_bit", ps2_dat_in, 1'b0);
        repeat ($urandom_range(2, 20)) tick();
        for (int i = 1; i <= 11; i++) begin
            dev_clk = 1'b0;
            for (int c = 0; c < hp; c++) begin
                tick();
                if (poke && i == 3 && c == 0) begin
                    chk("ready_low_busy", cmd_ready, 1'b0);
                    cmd_valid = 1'b1;
                    cmd_data  = ~b;
                end
                if (poke && i == 3 && c == 1) cmd_valid = 1'b0;
                if (i == abort_fall && c == 4) return;
            end
            dev_clk = 1'b1;
            if (i <= 10) cap[i-1] = ps2_dat_in;
            if (i == 10 && ack_ok) dev_dat = 1'b0;
            repeat (hp) tick();
        end
        dev_dat = 1'b1;
        expf = {1'b1, ($countones(b) % 2 == 0) ? 1'b1 : 1'b0, b};
        chk("frame_bits", cap, expf);
    endtask

    task automatic respond(input logic [7:0] r);
        int w = 0;
        while (!(busy && !rx_inhibit) && w < 100) begin
            tick();
            w++;
        end
        chk("wait_resp_reached", busy && !rx_inhibit, 1'b1);
        repeat ($urandom_range(0, 5)) tick();
        rx_byte   = r;
        rx_strobe = 1'b1;
        tick();
        rx_strobe = 1'b0;
        rx_byte   = 8'($urandom);
    endtask

    // One command end to end; the expected response sequence and outcome are
    // derived from the resend rules, not from the design's state machine.
    task automatic do_cmd(input logic [7:0] b, input int nfe, input logic [7:0] fin,
                          input bit ack_ok, input bit poke);
        logic [7:0] rq[$];
        int retries = 0;
        bit term = 1'b0;
        bit exp_done = 1'b0;
        bit exp_err = 1'b0;
        logic [1:0] exp_code = 2'd0;
        int d0 = n_done;
        int e0 = n_errp;
        int w = 0;
        logic [7:0] resp;
        if (!ack_ok) begin
            rq.push_back(8'h00);
            exp_err  = 1'b1;
            exp_code = 2'd1;
        end else begin
            for (int k = 0; k <= nfe && !term; k++) begin
                resp = (k < nfe) ? 8'hFE : fin;
                rq.push_back(resp);
                if (resp == 8'hFA) begin
                    exp_done = 1'b1;
                    term = 1'b1;
                end else if (resp == 8'hFE) begin
                    if (retries < MR) retries++;
                    else begin
                        exp_err = 1'b1; exp_code = 2'd2; term = 1'b1;
                    end
                end else begin
                    exp_err = 1'b1; exp_code = 2'd3; term = 1'b1;
                end
            end
        end
        accept(b);
        for (int a = 0; a < rq.size(); a++) begin
            inhibit_phase();
            device_xfer(b, ack_ok, 0, poke && a == 0);
            if (ack_ok) begin
                respond(rq[a]);
                if (a < rq.size() - 1) begin
                    chk("resend_inhibit", {ps2_clk_oe, busy, err, done}, 4'b1100);
                end else begin
                    chk("final_done", done, exp_done);
                    chk("final_err", err, exp_err);
                    chk("final_busy", busy, 1'b1);
                    if (exp_err) chk("final_err_code", err_code, exp_code);
                end
            end
        end
        while (busy && w < 50) begin
            tick();
            w++;
        end
        chk("idle_after", {busy, cmd_ready, ps2_clk_oe, ps2_dat_oe}, 4'b0100);
        chk("done_count", n_done - d0, exp_done ? 1 : 0);
        chk("err_count", n_errp - e0, exp_err ? 1 : 0);
        if (exp_err) chk("err_code_hold", err_code, exp_code);
        repeat (3) tick();
        chk("stays_idle", busy, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: observed no finish expected finish by 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int e0;
        logic [7:0] b;

        // Reset state
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("reset_outputs",
            {cmd_ready, ps2_clk_oe, ps2_dat_oe, rx_inhibit, busy, done, err, err_code},
            9'h100);
        reset_n = 1'b1;
        repeat (3) tick();

        // Set-LEDs with a clean ACK
        do_cmd(8'hED, 0, 8'hFA, 1'b1, 1'b0);
        chk("frame_ED_parity", ($countones(8'hED) % 2 == 0), 1'b1);

        // Two resends then ACK, then resends exhausted
        do_cmd(8'($urandom), 2, 8'hFA, 1'b1, 1'b0);
        do_cmd(8'hFF, 4, 8'hFA, 1'b1, 1'b0);

        // Device never clocks
        accept(8'($urandom));
        inhibit_phase();
        w = 0;
        while (!err && w < ST_TO + 50) begin
            tick();
            w++;
        end
        chk("start_to_err", err, 1'b1);
        chk("start_to_delay", t_err - t_req, ST_TO + 1);
        chk("start_to_code", err_code, 2'd0);
        chk("start_to_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        tick();
        chk("start_to_ready", cmd_ready, 1'b1);

        // No line-ACK, bad response byte
        do_cmd(8'($urandom), 0, 8'hFA, 1'b0, 1'b0);
        do_cmd(8'($urandom), 0, 8'hAA, 1'b1, 1'b0);

        // Silent device after line-ACK
        b = 8'($urandom);
        accept(b);
        inhibit_phase();
        device_xfer(b, 1'b1, 0, 1'b0);
        w = 0;
        while (!err && w < RSP_TO + 100) begin
            tick();
            w++;
        end
        chk("resp_to_err", err, 1'b1);
        chk("resp_to_delay", t_err - t_wr, RSP_TO + 1);
        chk("resp_to_code", err_code, 2'd3);
        tick();

        // Command offered while busy is dropped
        do_cmd(8'($urandom), 0, 8'hFA, 1'b1, 1'b1);

        // Reset during SEND bit 5
        b = 8'($urandom);
        e0 = n_errp;
        accept(b);
        inhibit_phase();
        device_xfer(b, 1'b1, 5, 1'b0);
        chk("mid_send_busy", {busy, rx_inhibit}, 2'b11);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_release", {ps2_clk_oe, ps2_dat_oe, busy}, 3'b000);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("post_reset_ready", {cmd_ready, err}, 2'b10);
        chk("post_reset_no_err", n_errp - e0, 0);
        do_cmd(8'($urandom), 1, 8'hFA, 1'b1, 1'b0);

        // Random mix
        for (int r = 0; r < 3; r++)
            do_cmd(8'($urandom), $urandom_range(0, 2), 8'hFA, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
